// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared constants for the pipeline stall controller: EX op codes the
//   controller decodes, stall-vector patterns (bit 0 = PC ... bit 5 = WB),
//   the EX sequencer state encoding, and small op-class helpers.
package pipe_ctrl_pkg;

  // EX-stage ALU op codes (EXE_*_OP)
  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  // Stall vectors: a stalled stage also stalls every stage upstream of it.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MAC1     = 2'd1,
    ST_DIV_RUN  = 2'd2,
    ST_DIV_DONE = 2'd3
  } ex_state_e;

  function automatic logic is_mac_op(input logic [7:0] op);
    return (op == EXE_MADD_OP) || (op == EXE_MADDU_OP) ||
           (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
  endfunction

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Pipeline stall controller and multi-cycle EX sequencer. Merges stall
//   requests from IF, ID, MEM and the EX sequencer into one stall vector,
//   and sequences 2-cycle MAC ops and the iterative divider.
//
// Ports
//   clk        core clock
//   rst        synchronous reset, active-low (0 = reset)
//   req_if     fetch waiting on memory
//   req_id     load-use hazard in ID
//   req_mem    data memory access not complete
//   flush      exception/redirect, aborts any EX sequence
//   ex_op      op code of the instruction in EX
//   div_zero   divisor of the EX instruction is zero
//   sg_stall   stall vector [0] PC .. [5] WB
//   ex_count   MAC phase: 00 first cycle, 01 accumulate cycle
//   div_start  one-cycle pulse: load divider operands
//   div_cnt    current divider step
//   div_done   divider result valid this cycle
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_if,
  input  logic       req_id,
  input  logic       req_mem,
  input  logic       flush,
  input  logic [7:0] ex_op,
  input  logic       div_zero,
  output logic [5:0] sg_stall,
  output logic [1:0] ex_count,
  output logic       div_start,
  output logic [5:0] div_cnt,
  output logic       div_done
);

  localparam logic [5:0] DIV_LAST = 6'(DIV_STEPS - 1);

  ex_state_e state;
  logic      op_mac;
  logic      op_div;
  logic      stallreq_ex;

  assign op_mac = is_mac_op(ex_op);
  assign op_div = is_div_op(ex_op);

  // EX sequencer outputs; all forced quiet while reset is asserted.
  always_comb begin
    stallreq_ex = 1'b0;
    ex_count    = 2'b00;
    div_start   = 1'b0;
    div_done    = 1'b0;
    if (rst) begin
      case (state)
        ST_IDLE: begin
          stallreq_ex = op_mac | op_div;
          // An op only launches when EX can actually advance.
          div_start   = op_div & ~req_mem & ~flush;
        end
        ST_MAC1:     ex_count    = 2'b01;
        ST_DIV_RUN:  stallreq_ex = 1'b1;
        ST_DIV_DONE: div_done    = 1'b1;
        default:     stallreq_ex = 1'b0;
      endcase
    end
  end

  // Priority encoder: the deepest stalled stage decides the vector.
  always_comb begin
    sg_stall = STALL_NONE;
    if (!rst || flush)    sg_stall = STALL_NONE;
    else if (req_mem)     sg_stall = STALL_MEM;
    else if (stallreq_ex) sg_stall = STALL_EX;
    else if (req_id)      sg_stall = STALL_ID;
    else if (req_if)      sg_stall = STALL_IF;
  end

  // Sequencer state. req_mem freezes EX, so the state holds with it.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      state   <= ST_IDLE;
      div_cnt <= 6'd0;
    end else if (!req_mem) begin
      case (state)
        ST_IDLE: begin
          if (op_mac) begin
            state <= ST_MAC1;
          end else if (op_div) begin
            div_cnt <= 6'd0;
            state   <= div_zero ? ST_DIV_DONE : ST_DIV_RUN;
          end
        end
        ST_MAC1: state <= ST_IDLE;
        ST_DIV_RUN: begin
          if (div_cnt == DIV_LAST) begin
            state   <= ST_DIV_DONE;
            div_cnt <= 6'd0;
          end else begin
            div_cnt <= div_cnt + 6'd1;
          end
        end
        ST_DIV_DONE: state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
//   Directed scenarios followed by randomized traffic, every cycle compared
//   against a job/progress model of the EX sequencer.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int DIV_STEPS = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_if, req_id, req_mem, flush;
  logic [7:0] ex_op;
  logic       div_zero;
  logic [5:0] sg_stall;
  logic [1:0] ex_count;
  logic       div_start;
  logic [5:0] div_cnt;
  logic       div_done;

  int n_cmp = 0;
  int n_err = 0;

  // Model: kind 0 = no job, 1 = MAC accumulate phase, 2 = divide job.
  // prog counts advancing EX cycles since the job launched.
  int m_kind = 0;
  int m_prog = 0;
  bit m_zero = 1'b0;
  bit last_stall3 = 1'b0;
  bit seen_done = 1'b0;

  pipe_ctrl #(.DIV_STEPS(DIV_STEPS)) dut (
    .clk(clk), .rst(rst), .req_if(req_if), .req_id(req_id),
    .req_mem(req_mem), .flush(flush), .ex_op(ex_op), .div_zero(div_zero),
    .sg_stall(sg_stall), .ex_count(ex_count), .div_start(div_start),
    .div_cnt(div_cnt), .div_done(div_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_done_phase();
    return (m_kind == 2) && (m_zero ? (m_prog == 1) : (m_prog == DIV_STEPS + 1));
  endfunction

  // One clock: compare at negedge, advance model at posedge.
  task automatic step();
    logic [5:0] e_stall;
    logic [5:0] e_dcnt;
    bit e_ex, e_acc, e_start, e_done, mac_in, div_in;
    @(negedge clk);
    mac_in = (ex_op == EXE_MADD_OP) || (ex_op == EXE_MADDU_OP) ||
             (ex_op == EXE_MSUB_OP) || (ex_op == EXE_MSUBU_OP);
    div_in = (ex_op == EXE_DIV_OP) || (ex_op == EXE_DIVU_OP);
    e_ex = 0; e_acc = 0; e_start = 0; e_done = 0; e_dcnt = 6'd0;
    if (m_kind == 0) begin
      e_ex    = mac_in || div_in;
      e_start = div_in && !req_mem && !flush;
    end else if (m_kind == 1) begin
      e_acc = 1;
    end else if (in_done_phase()) begin
      e_done = 1;
    end else begin
      e_ex   = 1;
      e_dcnt = 6'(m_prog - 1);
    end
    if (!rst) begin
      e_ex = 0; e_acc = 0; e_start = 0; e_done = 0;
    end
    if (!rst || flush) e_stall = 6'b000000;
    else if (req_mem)  e_stall = 6'b011111;
    else if (e_ex)     e_stall = 6'b001111;
    else if (req_id)   e_stall = 6'b000111;
    else if (req_if)   e_stall = 6'b000011;
    else               e_stall = 6'b000000;
    chk("sg_stall",  {2'b00, sg_stall}, {2'b00, e_stall});
    chk("ex_count",  {6'd0, ex_count},  {6'd0, e_acc, 1'b0} >> 1 | {6'd0, 1'b0, e_acc});
    chk("div_start", {7'd0, div_start}, {7'd0, e_start});
    chk("div_done",  {7'd0, div_done},  {7'd0, e_done});
    chk("div_cnt",   {2'b00, div_cnt},  {2'b00, e_dcnt});
    if (div_done === 1'b1) seen_done = 1'b1;
    last_stall3 = e_stall[3];
    @(posedge clk);
    if (!rst || flush) begin
      m_kind = 0; m_prog = 0;
    end else if (!req_mem) begin
      if (m_kind == 0) begin
        if (mac_in) m_kind = 1;
        else if (div_in) begin
          m_kind = 2; m_prog = 1; m_zero = div_zero;
        end
      end else if (m_kind == 1) begin
        m_kind = 0;
      end else if (in_done_phase()) begin
        m_kind = 0; m_prog = 0;
      end else begin
        m_prog++;
      end
    end
    #1;
  endtask

  // Launch op and step until the job has left EX; returns EX cycles used.
  task automatic run_op(input logic [7:0] op, input bit zero, output int cycles);
    ex_op = op; div_zero = zero; cycles = 0;
    do begin
      step();
      cycles++;
    end while (m_kind != 0 && cycles < 200);
    ex_op = EXE_NOP_OP; div_zero = 1'b0;
  endtask

  int  cyc;
  int  guard;
  int  mem_left;
  bit  pulsed;
  logic [7:0] ops [8];

  initial begin
    ops = '{EXE_NOP_OP, 8'h20, EXE_MADD_OP, EXE_MADDU_OP,
            EXE_MSUB_OP, EXE_MSUBU_OP, EXE_DIV_OP, EXE_DIVU_OP};
    rst = 1'b0; req_if = 0; req_id = 0; req_mem = 1; flush = 0;
    ex_op = EXE_NOP_OP; div_zero = 0;

    // Reset held two cycles with MEM requesting
    step(); step();
    rst = 1'b1; req_mem = 0;
    step();

    // MADD: stalled first cycle, accumulate second
    run_op(EXE_MADD_OP, 1'b0, cyc);
    chk("madd_cycles", 8'(cyc), 8'd2);
    step();

    // DIVU, non-zero divisor
    seen_done = 0;
    run_op(EXE_DIVU_OP, 1'b0, cyc);
    chk("divu_cycles", 8'(cyc), 8'(DIV_STEPS + 2));
    chk("divu_done_seen", {7'd0, seen_done}, 8'd1);

    // DIV with a 3-cycle MEM stall at step 10
    ex_op = EXE_DIV_OP; cyc = 0; pulsed = 0; mem_left = 0;
    do begin
      if (!pulsed && m_kind == 2 && m_prog == 11) begin
        pulsed = 1; mem_left = 3;
      end
      req_mem = (mem_left > 0);
      if (mem_left > 0) mem_left--;
      step();
      if (req_mem) chk("div_cnt_hold", {2'b00, div_cnt}, 8'd10);
      cyc++;
    end while (m_kind != 0 && cyc < 200);
    req_mem = 0; ex_op = EXE_NOP_OP;
    chk("div_mem_cycles", 8'(cyc), 8'(DIV_STEPS + 5));

    // Divide by zero finishes in two cycles
    run_op(EXE_DIV_OP, 1'b1, cyc);
    chk("divzero_cycles", 8'(cyc), 8'd2);

    // Request priority
    req_if = 1; req_id = 1; req_mem = 1; step();
    req_mem = 0; step();
    req_id = 0; step();
    req_if = 0; step();

    // Flush mid-divide at step 5
    ex_op = EXE_DIVU_OP; guard = 0;
    while (!(m_kind == 2 && m_prog == 6) && guard < 50) begin
      step(); guard++;
    end
    chk("flush_reach", {2'b00, div_cnt}, 8'd5);
    seen_done = 0;
    flush = 1; step();
    flush = 0; ex_op = EXE_NOP_OP;
    step(); step();
    chk("flush_no_done", {7'd0, seen_done}, 8'd0);

    // Back-to-back MAC then DIV with no gap
    ex_op = EXE_MSUB_OP; step(); step();
    ex_op = EXE_DIVU_OP; div_zero = 1; step(); step();
    ex_op = EXE_NOP_OP; div_zero = 0; step();

    // Randomized traffic; ex_op/div_zero only change when EX advanced
    for (int i = 0; i < 3000; i++) begin
      if (!last_stall3) begin
        ex_op    = ops[$urandom_range(0, 7)];
        div_zero = ($urandom_range(0, 5) == 0);
      end
      req_if  = ($urandom_range(0, 3) == 0);
      req_id  = ($urandom_range(0, 3) == 0);
      req_mem = ($urandom_range(0, 5) == 0);
      flush   = ($urandom_range(0, 40) == 0);
      rst     = ($urandom_range(0, 255) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
